pdm_mic_rx: RTL

- Capture front end for the audio path: drives the PDM microphone clock and samples the 1-bit PDM stream.
- Decimates the stream by counting ones over a 2^DEC_LOG2-bit window to produce unsigned PCM words.
- Sits upstream of the PWM playback generator. Its sample word feeds the PWM duty comparator directly; its done pulse is the generator's sample strobe.

---
 rtl/pdm_mic_rx_pkg.sv | 20 ++
 rtl/pdm_mic_rx_clk_gen.sv | 52 +++++
 rtl/pdm_mic_rx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pdm_mic_rx_pkg.sv
`default_nettype none
// ---- pdm_mic_rx_pkg : shared audio types/constants (also used by PWM playback) -- rev 1.0
package pdm_mic_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } pdm_state_e;

  localparam int CLK_DIV_DEF  = 25;
  localparam int DEC_LOG2_DEF = 6;

  // Largest representable sample; a full window of ones saturates to this.
  function automatic int unsigned win_max(input int unsigned dec_log2);
    return (32'd1 << dec_log2) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_mic_rx_clk_gen.sv
`default_nettype none
// ---- pdm_clk_gen : mic clock divider with a bit strobe on each falling mic_clk -- rev 1.0
module pdm_clk_gen
  import pdm_mic_rx_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic en,
  output logic mic_clk,
  output logic bit_stb
);

  localparam int            CW     = $clog2(CLK_DIV);
  localparam logic [CW-1:0] C_TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mic_q, mic_d;
  logic          w_term;

  always_comb begin
    w_term = (cnt_q == C_TERM);
    cnt_d  = cnt_q;
    mic_d  = mic_q;
    if (!en) begin
      cnt_d = '0;
      mic_d = 1'b0;
    end else if (w_term) begin
      cnt_d = '0;
      mic_d = ~mic_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      mic_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mic_q <= mic_d;
    end
  end

  // Data has been stable for a whole high phase when mic_clk falls.
  assign bit_stb = en && w_term && mic_q;
  assign mic_clk = mic_q;

endmodule
`default_nettype wire

// File: rtl/pdm_mic_rx.sv
`default_nettype none
// ---- pdm_mic_rx : PDM mic capture + ones-count decimator; optional PDM_RAW_CAPTURE_EN -- rev 1.0
module pdm_mic_rx
  import pdm_mic_rx_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int DEC_LOG2   = DEC_LOG2_DEF,
  parameter int WARMUP_WIN = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         pdm_data,
  output logic                         mic_clk,
  output logic [DEC_LOG2-1:0]          sample,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic                         done,
`ifdef PDM_RAW_CAPTURE_EN
  output logic [(2**DEC_LOG2)-1:0]     raw_bits,
`endif
  output logic                         overrun
);

  localparam int                NBITS       = 2 ** DEC_LOG2;
  localparam logic [DEC_LOG2:0] C_SAT       = (DEC_LOG2 + 1)'(win_max(DEC_LOG2));
  localparam logic [3:0]        C_WARM_LAST = 4'(WARMUP_WIN - 1);

  pdm_state_e          state_q, state_d;
  logic                sync1_q, pdm_s_q;
  logic [DEC_LOG2-1:0] bitcnt_q, bitcnt_d;
  logic [DEC_LOG2:0]   acc_q, acc_d;
  logic [3:0]          warm_q, warm_d;
  logic [DEC_LOG2-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  logic                w_run, w_stb, w_win_end, w_load;
  logic [DEC_LOG2:0]   w_result, w_sat;

  // Gating with enable stops mic_clk on the very edge enable is seen low.
  assign w_run = enable && (state_q != ST_IDLE);

  pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (w_run),
    .mic_clk (mic_clk),
    .bit_stb (w_stb)
  );

  assign w_win_end = w_stb && (bitcnt_q == '1);
  assign w_load    = w_win_end && (state_q == ST_RUN);
  assign w_result  = acc_q + {{DEC_LOG2{1'b0}}, pdm_s_q};
  assign w_sat     = (w_result > C_SAT) ? C_SAT : w_result;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    acc_d    = acc_q;
    warm_d   = warm_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q;

    if (!w_run) begin
      bitcnt_d = '0;
      acc_d    = '0;
      warm_d   = '0;
    end else if (w_stb) begin
      bitcnt_d = bitcnt_q + {{(DEC_LOG2-1){1'b0}}, 1'b1};
      acc_d    = w_win_end ? '0 : w_result;
    end

    if (valid_q && sample_ready) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = (WARMUP_WIN == 0) ? ST_RUN : ST_WARMUP;
      end
      ST_WARMUP: begin
        if (w_win_end) begin
          if (warm_q == C_WARM_LAST) state_d = ST_RUN;
          else                       warm_d  = warm_q + 4'd1;
        end
      end
      ST_RUN: begin
        if (w_load) begin
          sample_d = w_sat[DEC_LOG2-1:0];
          valid_d  = 1'b1;
          done_d   = 1'b1;
          if (valid_q && !sample_ready) ovr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Leaving capture keeps the pending word but forgives earlier overruns.
    if (!enable) begin
      state_d = ST_IDLE;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sync1_q  <= 1'b0;
      pdm_s_q  <= 1'b0;
      bitcnt_q <= '0;
      acc_q    <= '0;
      warm_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= pdm_data;
      pdm_s_q  <= sync1_q;
      bitcnt_q <= bitcnt_d;
      acc_q    <= acc_d;
      warm_q   <= warm_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

`ifdef PDM_RAW_CAPTURE_EN
  logic [NBITS-1:0] shift_q, raw_q;
  logic [NBITS-1:0] w_shift_nx;

  assign w_shift_nx = {shift_q[NBITS-2:0], pdm_s_q};

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      raw_q   <= '0;
    end else begin
      if (w_stb)  shift_q <= w_shift_nx;
      if (w_load) raw_q   <= w_shift_nx;
    end
  end

  assign raw_bits = raw_q;
`endif

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign done         = done_q;
  assign overrun      = ovr_q;

endmodule
`default_nettype wire
